vdc_ram_sched: RTL and testbench
================================

# vdc_ram_sched

Slot scheduler for the VDC's single-port video RAM. It gives one RAM access per pixel-clock slot to one of four requesters: display fetch, DRAM refresh, CPU update port (R31 read/write) and block copy/fill engine. It also applies the 16K/64K address fold. It sits between the register/bus logic and the video RAM macro, alongside the display signal generator.

## Interface
Parameters:
- RAM_ADDR_BITS, 16, width of physical RAM address
- STARVE_LIMIT, 8, consecutive denied slots after which the update port outranks refresh and block (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  slot strobe; never high on two consecutive clk cycles
- ram64k  in  1  1 = 64K RAM fitted
- reg_ram  in  1  R28[4]; 1 = 64K addressing enabled
- line_start  in  1  one-clk pulse at start of each scan line
- reg_drr  in  4  refresh cycles per line (R36)
- disp_req / blk_req / upd_req  in  1 each  access request, held until ack
- disp_addr / blk_addr / upd_addr  in  16 each  request address
- blk_we / upd_we  in  1 each  1 = write
- blk_wdata / upd_wdata  in  8 each  write data
- disp_ack / blk_ack / upd_ack  out  1 each  one-clk grant pulse
- rvalid  out  1  read data valid pulse
- rid  out  2  owner of rvalid: 0 disp, 1 refresh, 2 upd, 3 blk
- rdata  out  8  read data
- ram_addr  out  RAM_ADDR_BITS  RAM address
- ram_we  out  1  RAM write strobe
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data, valid one clk after ram_addr is presented
- upd_busy  out  1  update request pending and not yet granted
- refresh_overrun  out  1  sticky: a line started with refresh cycles still owed

## Operation
- One access per slot. Arbitration is evaluated only in clk cycles where enable=1.
- Base priority: disp > refresh (owed count ≠ 0) > upd > blk.
- Starvation: upd_wait (4-bit) increments on each slot where upd_req=1 and the port is not granted, saturating at 15. It clears when upd is granted. When upd_wait ≥ STARVE_LIMIT, upd ranks above refresh and blk but never above disp.
- Refresh: line_start loads the owed count from reg_drr. If the owed count is nonzero at that moment, refresh_overrun sets and the leftover is discarded. Each refresh grant decrements the owed count and presents {8'h00, rfsh_ctr} as a read. rfsh_ctr is 8 bits and wraps from FF to 00. Refresh reads produce rvalid with rid=1.
- Address fold: effective address = (ram64k & reg_ram) ? addr : addr & 16'h3FFF, truncated to RAM_ADDR_BITS.
- Writes produce no rvalid. Reads produce exactly one rvalid.
- With no request and nothing owed: ram_we=0 and ram_addr holds its last value.
- line_start and enable in the same cycle: the reload happens first, and that slot arbitrates against the new owed count.

## Timing
- Cycle N (enable=1): arbitration.
- Cycle N+1: the winner's *_ack pulses, and ram_addr/ram_we/ram_din are registered and presented. ram_we is high for exactly this one cycle.
- Cycle N+2: for reads, rvalid=1, rid=winner, rdata=ram_dout.
- A requester may drop or change its request in the cycle after its ack. A request seen at N and granted at N+1 is never granted twice.
- upd_busy is registered: it is 1 from the cycle after upd_req rises until the upd_ack cycle inclusive.
- Reset values: every ack=0, rvalid=0, rid=0, rdata=0, ram_addr=0, ram_we=0, ram_din=0, upd_busy=0, refresh_overrun=0. Internal state also resets: owed count=0, rfsh_ctr=0, upd_wait=0.
- Reset in cycle N+1 or N+2 of an access suppresses the pending ack, ram_we and rvalid.

## Configuration
- VDC_REFRESH_EN defined: refresh requester, owed counter and refresh_overrun behave as above.
- VDC_REFRESH_EN undefined: no refresh slots are ever issued, reg_drr and line_start are ignored, refresh_overrun is tied to 0, and rid=1 never occurs. All other behaviour is unchanged.

## Test plan
- disp_req and upd_req both held, with enable every 2 clk: disp_ack at N+1 for every slot; upd_ack never fires. upd_wait saturates without overriding disp.
- reg_drr=5, pulse line_start, upd_req held, no disp: 5 refresh reads with addresses 00..04 and rid=1, then upd_ack on the 6th slot (with STARVE_LIMIT=8). Second line: addresses 05..09.
- reg_drr=15, line_start pulsed again after 3 slots: refresh_overrun=1 and stays 1; owed count reloads to 15.
- blk_req and upd_req held, no refresh owed: upd granted first; blk granted only when upd_req=0.
- ram64k=1, reg_ram=0, upd write to 16'hC123: ram_addr=16'h0123. With reg_ram=1: ram_addr=16'hC123. ram_we is high for exactly one clk.
- upd read at 16'h0010 with RAM byte 8'hA5: upd_ack at N+1, rvalid with rid=2 and rdata=8'hA5 at N+2. Asserting reset at N+1: no rvalid, and all outputs are at reset values the next cycle.

Source files
------------

// File: rtl/vdc_ram_sched_if.sv
// Requester-side bundle of the VDC video-RAM slot scheduler: requests, grants and read return.
interface vdc_ram_sched_if;
  logic        disp_req;
  logic        blk_req;
  logic        upd_req;
  logic [15:0] disp_addr;
  logic [15:0] blk_addr;
  logic [15:0] upd_addr;
  logic        blk_we;
  logic        upd_we;
  logic [7:0]  blk_wdata;
  logic [7:0]  upd_wdata;
  logic        disp_ack;
  logic        blk_ack;
  logic        upd_ack;
  logic        rvalid;
  logic [1:0]  rid;
  logic [7:0]  rdata;
  logic        upd_busy;

  modport master (
    output disp_req, blk_req, upd_req, disp_addr, blk_addr, upd_addr,
           blk_we, upd_we, blk_wdata, upd_wdata,
    input  disp_ack, blk_ack, upd_ack, rvalid, rid, rdata, upd_busy
  );

  modport slave (
    input  disp_req, blk_req, upd_req, disp_addr, blk_addr, upd_addr,
           blk_we, upd_we, blk_wdata, upd_wdata,
    output disp_ack, blk_ack, upd_ack, rvalid, rid, rdata, upd_busy
  );
endinterface

// File: rtl/vdc_ram_sched.sv
// One video-RAM access per enable slot: disp > refresh > upd > blk, upd promoted when starved.
// Refresh requester is built only when VDC_REFRESH_EN is defined.
module vdc_ram_sched #(
  parameter int RAM_ADDR_BITS = 16,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     ram64k,
  input  logic                     reg_ram,
  input  logic                     line_start,
  input  logic [3:0]               reg_drr,
  vdc_ram_sched_if.slave           bus,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic                     ram_we,
  output logic [7:0]               ram_din,
  input  logic [7:0]               ram_dout,
  output logic                     refresh_overrun
);

  typedef enum logic [1:0] {
    SRC_DISP = 2'd0,
    SRC_RFSH = 2'd1,
    SRC_UPD  = 2'd2,
    SRC_BLK  = 2'd3
  } src_t;

  localparam logic [3:0] STARVE_TH = 4'(STARVE_LIMIT);

  logic [3:0]  upd_wait;
  logic [3:0]  owed_eff;
  logic [7:0]  rfsh_ctr;
  logic        upd_starved;
  logic        win_vld;
  src_t        win_id;
  logic        grant;
  logic [15:0] sel_addr;
  logic        sel_we;
  logic [7:0]  sel_din;
  logic [15:0] eff_addr;

  logic        disp_ack_q;
  logic        blk_ack_q;
  logic        upd_ack_q;
  logic        rd_pend;
  src_t        rid_pend;
  logic        rvalid_q;
  logic [1:0]  rid_q;
  logic        upd_busy_q;

`ifdef VDC_REFRESH_EN
  logic [3:0] owed;

  // A line_start in the same cycle as a slot reloads first, so the slot sees the new count.
  assign owed_eff = line_start ? reg_drr : owed;

  always_ff @(posedge clk) begin
    if (reset) begin
      owed            <= 4'd0;
      rfsh_ctr        <= 8'h00;
      refresh_overrun <= 1'b0;
    end else begin
      if (line_start && owed != 4'd0)
        refresh_overrun <= 1'b1;
      if (grant && win_id == SRC_RFSH) begin
        owed     <= owed_eff - 4'd1;
        rfsh_ctr <= rfsh_ctr + 8'd1;
      end else if (line_start) begin
        owed <= reg_drr;
      end
    end
  end
`else
  logic unused_rfsh_inputs;

  assign unused_rfsh_inputs = ^{line_start, reg_drr};
  assign owed_eff           = 4'd0;
  assign rfsh_ctr           = 8'h00;
  assign refresh_overrun    = 1'b0;
`endif

  assign upd_starved = (upd_wait >= STARVE_TH);
  assign grant       = enable & win_vld;

  always_comb begin
    win_vld = 1'b1;
    win_id  = SRC_DISP;
    if (bus.disp_req)                      win_id = SRC_DISP;
    else if (bus.upd_req && upd_starved)   win_id = SRC_UPD;
    else if (owed_eff != 4'd0)             win_id = SRC_RFSH;
    else if (bus.upd_req)                  win_id = SRC_UPD;
    else if (bus.blk_req)                  win_id = SRC_BLK;
    else                                   win_vld = 1'b0;

    sel_addr = bus.disp_addr;
    sel_we   = 1'b0;
    sel_din  = 8'h00;
    case (win_id)
      SRC_RFSH: sel_addr = {8'h00, rfsh_ctr};
      SRC_UPD: begin
        sel_addr = bus.upd_addr;
        sel_we   = bus.upd_we;
        sel_din  = bus.upd_wdata;
      end
      SRC_BLK: begin
        sel_addr = bus.blk_addr;
        sel_we   = bus.blk_we;
        sel_din  = bus.blk_wdata;
      end
      default: ;
    endcase

    // Without 64K RAM and 64K mode, the top two address bits are ignored.
    eff_addr = (ram64k & reg_ram) ? sel_addr : (sel_addr & 16'h3FFF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_ack_q <= 1'b0;
      blk_ack_q  <= 1'b0;
      upd_ack_q  <= 1'b0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_din    <= 8'h00;
      rd_pend    <= 1'b0;
      rid_pend   <= SRC_DISP;
      rvalid_q   <= 1'b0;
      rid_q      <= 2'd0;
      upd_busy_q <= 1'b0;
      upd_wait   <= 4'd0;
    end else begin
      disp_ack_q <= 1'b0;
      blk_ack_q  <= 1'b0;
      upd_ack_q  <= 1'b0;
      ram_we     <= 1'b0;
      rd_pend    <= 1'b0;
      rvalid_q   <= rd_pend;
      if (rd_pend)
        rid_q <= rid_pend;
      upd_busy_q <= bus.upd_req & ~upd_ack_q;

      if (grant) begin
        ram_addr <= RAM_ADDR_BITS'(eff_addr);
        ram_we   <= sel_we;
        if (sel_we)
          ram_din <= sel_din;
        rd_pend  <= ~sel_we;
        rid_pend <= win_id;
        disp_ack_q <= (win_id == SRC_DISP);
        upd_ack_q  <= (win_id == SRC_UPD);
        blk_ack_q  <= (win_id == SRC_BLK);
      end

      if (enable) begin
        if (win_vld && win_id == SRC_UPD)
          upd_wait <= 4'd0;
        else if (bus.upd_req && upd_wait != 4'hF)
          upd_wait <= upd_wait + 4'd1;
      end
    end
  end

  assign bus.disp_ack = disp_ack_q;
  assign bus.blk_ack  = blk_ack_q;
  assign bus.upd_ack  = upd_ack_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rid      = rid_q;
  // Synchronous RAM output is only meaningful in the rvalid cycle.
  assign bus.rdata    = rvalid_q ? ram_dout : 8'h00;
  assign bus.upd_busy = upd_busy_q;

endmodule

// File: tb/tb_vdc_ram_sched.sv
// Bench for vdc_ram_sched: directed literal checks plus randomized traffic against a slot-level model.
module tb_vdc_ram_sched;
  localparam int STARVE_LIMIT = 8;
`ifdef VDC_REFRESH_EN
  localparam bit RFSH_EN = 1'b1;
`else
  localparam bit RFSH_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        enable;
  logic        ram64k;
  logic        reg_ram;
  logic        line_start;
  logic [3:0]  reg_drr;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        refresh_overrun;

  vdc_ram_sched_if bus();

  vdc_ram_sched #(.RAM_ADDR_BITS(16), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ram64k(ram64k), .reg_ram(reg_ram),
    .line_start(line_start), .reg_drr(reg_drr), .bus(bus), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout), .refresh_overrun(refresh_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Video RAM: one-cycle synchronous read.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  int total = 0;
  int bad = 0;

  // Model: RAM contents, owed refreshes, refresh counter, starvation counter, sticky overrun.
  logic [7:0] mmem [0:65535];
  int m_owed = 0, m_ctr = 0, m_wait = 0;
  bit m_ovr = 0;
  // Expected outputs for the current cycle.
  bit e_ack_d = 0, e_ack_b = 0, e_ack_u = 0, e_we = 0, e_rdp = 0, e_rv = 0, e_busy = 0, e_ovr = 0;
  logic [1:0]  e_rid = 0, e_ridp = 0;
  logic [7:0]  e_din = 0, e_rdata = 0;
  logic [15:0] e_addr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    int w, owed_now;
    logic [15:0] a;
    bit we;
    logic [7:0] din;
    bit n_d = 0, n_b = 0, n_u = 0, n_we = 0, n_rdp = 0, n_rv, n_busy;
    logic [1:0] n_rid, n_ridp;
    logic [7:0] n_din, n_rdata;
    logic [15:0] n_addr;

    // Effect of the access presented this cycle.
    if (e_we) mmem[e_addr] = e_din;
    n_rv    = e_rdp;
    n_rdata = e_rdp ? mmem[e_addr] : 8'h00;
    n_rid   = e_rdp ? e_ridp : e_rid;
    n_addr  = e_addr;
    n_din   = e_din;
    n_ridp  = e_ridp;
    n_busy  = bus.upd_req && !e_ack_u;

    owed_now = (RFSH_EN && line_start) ? int'(reg_drr) : m_owed;
    if (RFSH_EN && line_start && m_owed != 0) m_ovr = 1;
    m_owed = owed_now;

    if (enable) begin
      w = -1;
      if (bus.disp_req) w = 0;
      else if (bus.upd_req && m_wait >= STARVE_LIMIT) w = 2;
      else if (owed_now > 0) w = 1;
      else if (bus.upd_req) w = 2;
      else if (bus.blk_req) w = 3;
      a = 16'h0; we = 0; din = 8'h00;
      case (w)
        0: a = bus.disp_addr;
        1: begin
          a = 16'(m_ctr);
          m_ctr = (m_ctr + 1) % 256;
          m_owed = m_owed - 1;
        end
        2: begin a = bus.upd_addr; we = bus.upd_we; din = bus.upd_wdata; end
        3: begin a = bus.blk_addr; we = bus.blk_we; din = bus.blk_wdata; end
        default: ;
      endcase
      if (w >= 0) begin
        n_addr = (ram64k && reg_ram) ? a : (a % 16'h4000);
        n_we   = we;
        if (we) n_din = din;
        n_rdp  = !we;
        n_ridp = 2'(w);
        n_d = (w == 0); n_u = (w == 2); n_b = (w == 3);
      end
      if (w == 2) m_wait = 0;
      else if (bus.upd_req) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    end

    if (reset) begin
      n_d = 0; n_b = 0; n_u = 0; n_we = 0; n_rdp = 0; n_rv = 0; n_busy = 0;
      n_rid = 0; n_ridp = 0; n_din = 0; n_rdata = 0; n_addr = 0;
      m_owed = 0; m_ctr = 0; m_wait = 0; m_ovr = 0;
    end

    e_ack_d = n_d; e_ack_b = n_b; e_ack_u = n_u; e_we = n_we; e_rdp = n_rdp;
    e_rv = n_rv; e_busy = n_busy; e_rid = n_rid; e_ridp = n_ridp;
    e_din = n_din; e_rdata = n_rdata; e_addr = n_addr; e_ovr = m_ovr;
  endtask

  task automatic compare();
    chk("disp_ack", bus.disp_ack, e_ack_d);
    chk("blk_ack", bus.blk_ack, e_ack_b);
    chk("upd_ack", bus.upd_ack, e_ack_u);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_din", ram_din, e_din);
    chk("rvalid", bus.rvalid, e_rv);
    chk("rid", bus.rid, e_rid);
    if (e_rv) chk("rdata", bus.rdata, e_rdata);
    chk("upd_busy", bus.upd_busy, e_busy);
    chk("refresh_overrun", refresh_overrun, e_ovr);
  endtask

  // Inputs are already set for this cycle; advance one clock and check at the falling edge.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Present a slot; returns in the following cycle (N+1) with enable dropped.
  task automatic slot_n1();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic drive_random();
    reset  = ($urandom_range(0, 599) == 0);
    enable = !enable && ($urandom_range(0, 2) != 0);
    line_start = ($urandom_range(0, 39) == 0);
    if ($urandom_range(0, 99) == 0) reg_drr = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 63) == 0) ram64k = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 63) == 0) reg_ram = 1'($urandom_range(0, 1));
    if (bus.disp_req) begin
      if (e_ack_d) begin
        if ($urandom_range(0, 3) != 0) bus.disp_req = 1'b0;
        else bus.disp_addr = 16'($urandom);
      end
    end else if ($urandom_range(0, 9) == 0) begin
      bus.disp_req = 1'b1; bus.disp_addr = 16'($urandom);
    end
    if (bus.upd_req) begin
      if (e_ack_u) begin
        if ($urandom_range(0, 1) != 0) bus.upd_req = 1'b0;
        else begin
          bus.upd_addr = 16'($urandom); bus.upd_we = 1'($urandom); bus.upd_wdata = 8'($urandom);
        end
      end
    end else if ($urandom_range(0, 4) == 0) begin
      bus.upd_req = 1'b1;
      bus.upd_addr = 16'($urandom); bus.upd_we = 1'($urandom); bus.upd_wdata = 8'($urandom);
    end
    if (bus.blk_req) begin
      if (e_ack_b && $urandom_range(0, 2) == 0) bus.blk_req = 1'b0;
      else if (e_ack_b) begin
        bus.blk_addr = 16'($urandom); bus.blk_we = 1'($urandom); bus.blk_wdata = 8'($urandom);
      end
    end else if ($urandom_range(0, 4) == 0) begin
      bus.blk_req = 1'b1;
      bus.blk_addr = 16'($urandom); bus.blk_we = 1'($urandom); bus.blk_wdata = 8'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]  <= 8'(i ^ (i >> 8) ^ 8'h3C);
      mmem[i] = 8'(i ^ (i >> 8) ^ 8'h3C);
    end
    reset = 1'b1; enable = 1'b0; ram64k = 1'b0; reg_ram = 1'b0; line_start = 1'b0; reg_drr = 4'd0;
    bus.disp_req = 0; bus.blk_req = 0; bus.upd_req = 0;
    bus.disp_addr = 0; bus.blk_addr = 0; bus.upd_addr = 0;
    bus.blk_we = 0; bus.upd_we = 0; bus.blk_wdata = 0; bus.upd_wdata = 0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_upd_busy", bus.upd_busy, 0);
    tick();

    // Display always wins over a held update request.
    bus.disp_req = 1; bus.disp_addr = 16'h0040;
    bus.upd_req = 1; bus.upd_we = 0; bus.upd_addr = 16'h0100;
    for (int k = 0; k < 20; k++) begin
      slot_n1();
      chk("disp_over_upd_dack", bus.disp_ack, 1);
      chk("disp_over_upd_uack", bus.upd_ack, 0);
      tick();
    end
    bus.disp_req = 0;
    slot_n1();
    chk("upd_after_disp", bus.upd_ack, 1);
    bus.upd_req = 0;
    tick();

`ifdef VDC_REFRESH_EN
    // Five refresh reads per line ahead of a non-starved update request.
    for (int ln = 0; ln < 2; ln++) begin
      reg_drr = 4'd5; line_start = 1; tick(); line_start = 0;
      bus.upd_req = 1; bus.upd_we = 0; bus.upd_addr = 16'h0200;
      for (int k = 0; k < 6; k++) begin
        slot_n1();
        if (k < 5) begin
          chk("rfsh_addr", ram_addr, 32'(ln * 5 + k));
          chk("rfsh_no_uack", bus.upd_ack, 0);
        end else begin
          chk("upd_after_rfsh", bus.upd_ack, 1);
          bus.upd_req = 0;
        end
        tick();
        chk("rfsh_rid", bus.rid, (k < 5) ? 1 : 2);
      end
    end
    chk("no_overrun_yet", refresh_overrun, 0);

    // New line while refreshes are still owed.
    reg_drr = 4'd15; line_start = 1; tick(); line_start = 0;
    for (int k = 0; k < 3; k++) begin
      slot_n1();
      chk("ovr_pre_addr", ram_addr, 32'(10 + k));
      tick();
    end
    line_start = 1; tick(); line_start = 0;
    chk("overrun_set", refresh_overrun, 1);
    for (int k = 0; k < 15; k++) begin
      slot_n1();
      chk("ovr_reload_addr", ram_addr, 32'(13 + k));
      tick();
    end
    slot_n1();
    tick();
    chk("rfsh_drained_rvalid", bus.rvalid, 0);
    chk("rfsh_drained_addr", ram_addr, 32'h1B);
    chk("overrun_sticky", refresh_overrun, 1);
`endif

    // Update outranks block; block served once update drops.
    bus.blk_req = 1; bus.blk_we = 0; bus.blk_addr = 16'h0300;
    bus.upd_req = 1; bus.upd_we = 0; bus.upd_addr = 16'h0301;
    for (int r = 0; r < 2; r++) begin
      slot_n1();
      chk("upd_over_blk_u", bus.upd_ack, 1);
      chk("upd_over_blk_b", bus.blk_ack, 0);
      bus.upd_req = 0;
      tick();
      slot_n1();
      chk("blk_when_idle", bus.blk_ack, 1);
      bus.upd_req = 1;
      tick();
    end
    bus.blk_req = 0; bus.upd_req = 0;
    tick();

    // Address fold for 16K vs 64K mode.
    ram64k = 1; reg_ram = 0;
    for (int r = 0; r < 2; r++) begin
      bus.upd_req = 1; bus.upd_we = 1; bus.upd_addr = 16'hC123; bus.upd_wdata = 8'h5A;
      slot_n1();
      chk("fold_addr", ram_addr, (r == 0) ? 32'h0123 : 32'hC123);
      chk("fold_we_on", ram_we, 1);
      bus.upd_req = 0;
      tick();
      chk("fold_we_off", ram_we, 0);
      reg_ram = 1;
    end

    // Write A5 to 0x0010, then read it back.
    bus.upd_req = 1; bus.upd_we = 1; bus.upd_addr = 16'h0010; bus.upd_wdata = 8'hA5;
    slot_n1(); bus.upd_req = 0; tick();
    bus.upd_req = 1; bus.upd_we = 0;
    slot_n1();
    chk("rd_ack_n1", bus.upd_ack, 1);
    bus.upd_req = 0;
    tick();
    chk("rd_rvalid_n2", bus.rvalid, 1);
    chk("rd_rid_n2", bus.rid, 2);
    chk("rd_rdata_n2", bus.rdata, 8'hA5);

    // Reset in N+1 kills the pending read.
    bus.upd_req = 1;
    slot_n1();
    reset = 1; bus.upd_req = 0;
    tick();
    chk("rstn1_rvalid", bus.rvalid, 0);
    chk("rstn1_addr", ram_addr, 0);
    chk("rstn1_din", ram_din, 0);
    chk("rstn1_rid", bus.rid, 0);
    chk("rstn1_uack", bus.upd_ack, 0);
    chk("rstn1_ovr", refresh_overrun, 0);
    reset = 0;
    tick();

    for (int c = 0; c < 4000; c++) begin
      drive_random();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
